// File: rtl/gpio_pin_debounce.sv
// gpio_pin_debounce
// Input conditioning between the GPIO pads and the GPIO block's pin input bus.
// Each pin is synchronised by two flops and then either passed straight
// through (bypass) or filtered by a counter debouncer. The debouncer advances
// on a sample tick from one prescaler shared by all pins. Each pin also has a
// registered one-cycle pulse that marks a change of its clean level.

module gpio_pin_debounce #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8,
    parameter int PRE_W = 12
) (
    input  logic             pclk,
    input  logic             n_p_reset,
    input  logic [WIDTH-1:0] pad_in,
    input  logic [WIDTH-1:0] debounce_en,
    input  logic [CNT_W-1:0] deb_limit,
    input  logic [PRE_W-1:0] prescale,
    output logic [WIDTH-1:0] pin_clean,
    output logic [WIDTH-1:0] pin_change
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [PRE_W-1:0] r_pre_cnt;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] r_clean;
    logic [WIDTH-1:0] r_change;

    logic             w_tick;
    logic             w_lim_small;
    logic [CNT_W-1:0] w_lim_m1;
    logic [WIDTH-1:0] w_clean_nxt;
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];

    // Tick when the prescaler reaches the programmed period. A count that is
    // already above a newly lowered prescale simply runs on until it wraps.
    always_comb begin
        w_tick      = (r_pre_cnt == prescale);
        w_lim_small = (deb_limit <= CNT_ONE);
        w_lim_m1    = deb_limit - CNT_ONE;
    end

    // Two-flop synchroniser; it is the only logic that samples the pads.
    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pad_in;
            r_sync2 <= r_sync1;
        end
    end

    // Shared sample-tick prescaler. It counts 0..prescale and then wraps to 0.
    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            r_pre_cnt <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + PRE_ONE;
        end
    end

    // Per-pin next level and next count for the bypass and debounce modes.
    // In bypass the count is cleared, so re-enabling debounce starts from zero.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_clean_nxt[i] = r_clean[i];
            w_cnt_nxt[i]   = r_cnt[i];
            if (!debounce_en[i]) begin
                w_clean_nxt[i] = r_sync2[i];
                w_cnt_nxt[i]   = '0;
            end else if (r_sync2[i] == r_clean[i]) begin
                w_cnt_nxt[i]   = '0;
            end else if (!w_tick) begin
                w_cnt_nxt[i]   = r_cnt[i];
            end else if (w_lim_small || (r_cnt[i] == w_lim_m1)) begin
                w_clean_nxt[i] = r_sync2[i];
                w_cnt_nxt[i]   = '0;
            end else begin
                w_cnt_nxt[i]   = r_cnt[i] + CNT_ONE;
            end
        end
    end

    // Per-pin debounce counters.
    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Clean levels, and a change pulse that is high in the cycle after a level moves.
    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            r_clean  <= '0;
            r_change <= '0;
        end else begin
            r_clean  <= w_clean_nxt;
            r_change <= r_clean ^ w_clean_nxt;
        end
    end

    assign pin_clean  = r_clean;
    assign pin_change = r_change;

endmodule

// File: tb/tb_gpio_pin_debounce.sv
// Directed bench for gpio_pin_debounce. Inputs are driven 1 ns after each
// rising edge, and outputs are sampled at the same point.

module tb_gpio_pin_debounce;

    logic        pclk;
    logic        n_p_reset;
    logic [15:0] pad_in;
    logic [15:0] debounce_en;
    logic [7:0]  deb_limit;
    logic [11:0] prescale;
    logic [15:0] pin_clean;
    logic [15:0] pin_change;

    int vectors;
    int miscompares;

    gpio_pin_debounce #(.WIDTH(16), .CNT_W(8), .PRE_W(12)) dut (
        .pclk        (pclk),
        .n_p_reset   (n_p_reset),
        .pad_in      (pad_in),
        .debounce_en (debounce_en),
        .deb_limit   (deb_limit),
        .prescale    (prescale),
        .pin_clean   (pin_clean),
        .pin_change  (pin_change)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        n_p_reset   = 1'b0;
        pad_in      = 16'hFFFF;
        debounce_en = 16'h0000;
        deb_limit   = 8'd4;
        prescale    = 12'd0;

        // 1. Reset with all pads high, then release in bypass mode
        repeat (3) step();
        check("rst_clean", {16'h0, pin_clean}, 32'h0);
        check("rst_change", {16'h0, pin_change}, 32'h0);
        n_p_reset = 1'b1;
        step();
        check("rel_e1_clean", {16'h0, pin_clean}, 32'h0);
        step();
        check("rel_e2_clean", {16'h0, pin_clean}, 32'h0);
        step();
        check("rel_e3_clean", {16'h0, pin_clean}, 32'h0000FFFF);
        check("rel_e3_change", {16'h0, pin_change}, 32'h0000FFFF);
        step();
        check("rel_e4_change", {16'h0, pin_change}, 32'h0);

        // 2. Bypass: pin 3 rises two edges after it is captured
        pad_in = 16'h0000;
        repeat (4) step();
        check("byp_low_clean", {16'h0, pin_clean}, 32'h0);
        check("byp_low_change", {16'h0, pin_change}, 32'h0);
        pad_in = 16'h0008;
        step();
        check("byp_n_clean", {16'h0, pin_clean}, 32'h0);
        step();
        check("byp_n1_clean", {16'h0, pin_clean}, 32'h0);
        step();
        check("byp_n2_clean", {16'h0, pin_clean}, 32'h00000008);
        check("byp_n2_change", {16'h0, pin_change}, 32'h00000008);
        step();
        check("byp_n3_change", {16'h0, pin_change}, 32'h0);
        check("byp_n3_clean", {16'h0, pin_clean}, 32'h00000008);

        // 3. Debounce pin 0, tick every cycle, limit 4: rises at sync edge + 4
        debounce_en = 16'h0001;
        pad_in      = 16'h0009;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("deb_wait_clean", {16'h0, pin_clean}, 32'h00000008);
        end
        step();
        check("deb_rise_clean", {16'h0, pin_clean}, 32'h00000009);
        check("deb_rise_change", {16'h0, pin_change}, 32'h00000001);
        step();
        check("deb_rise_change_off", {16'h0, pin_change}, 32'h0);

        // 4. Glitch rejection: two cycles high are not enough
        pad_in = 16'h0008;
        repeat (8) step();
        check("glt_fall_clean", {16'h0, pin_clean}, 32'h00000008);
        pad_in = 16'h0009;
        step();
        step();
        pad_in = 16'h0008;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("glt_clean", {16'h0, pin_clean}, 32'h00000008);
            check("glt_change", {16'h0, pin_change}, 32'h0);
        end
        check("glt_cnt", {24'h0, dut.r_cnt[0]}, 32'h0);

        // 5. Prescaled ticks on pin 5: ticks land on edges 10, 20, 30 from here
        debounce_en = 16'h0021;
        prescale    = 12'd9;
        deb_limit   = 8'd3;
        pad_in      = 16'h0028;
        repeat (29) step();
        check("pre_e29_clean", {16'h0, pin_clean}, 32'h00000008);
        step();
        check("pre_e30_clean", {16'h0, pin_clean}, 32'h00000028);
        check("pre_e30_change", {16'h0, pin_change}, 32'h00000020);
        // limit 0 acts as 1: the next tick (10 edges later) accepts the fall
        deb_limit = 8'd0;
        pad_in    = 16'h0008;
        repeat (9) step();
        check("lim0_e9_clean", {16'h0, pin_clean}, 32'h00000028);
        step();
        check("lim0_e10_clean", {16'h0, pin_clean}, 32'h00000008);
        check("lim0_e10_change", {16'h0, pin_change}, 32'h00000020);

        // 6. Leaving debounce mid-count takes the synchronised level at once
        prescale    = 12'd0;
        deb_limit   = 8'd200;
        debounce_en = 16'h00A1;
        pad_in      = 16'h0088;
        repeat (10) step();
        check("mode_counting_clean", {16'h0, pin_clean}, 32'h00000008);
        debounce_en = 16'h0021;
        step();
        check("mode_bypass_clean", {16'h0, pin_clean}, 32'h00000088);
        check("mode_bypass_change", {16'h0, pin_change}, 32'h00000080);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
